// File: rtl/apb_mem_bridge_pkg.sv
// Shared definitions for the APB-to-memory bridge: FSM encoding, APB
// response codes and default bus widths.
package apb_mem_defs;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/apb_mem_bridge.sv
// APB completer driving a single-port synchronous memory with 1-cycle read
// latency. Every output is decoded from registered state or data registers.
module apb_mem_bridge
    import apb_mem_defs::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              mem_ce,
    output logic              mem_wren,
    output logic              mem_rden,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output state_t            o_dbg_state
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    // Handshake: a transfer is accepted on a setup cycle (psel=1, penable=0)
    // seen in IDLE; it completes on the single cycle where pready=1, and
    // psel falling before that abandons it at the next edge.

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [DATA_W-1:0]   r_prdata;

    state_t              w_next;
    logic [3:0]          w_cnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic                w_write;
    logic [DATA_W-1:0]   w_prdata;
    logic                w_in_range;

    assign w_in_range = (int'(paddr) < MEM_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_prdata <= '0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_write  <= w_write;
            r_prdata <= w_prdata;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_cnt    = r_cnt;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_write  = r_write;
        w_prdata = r_prdata;
        case (r_state)
            ST_IDLE: begin
                if (psel && !penable) begin
                    w_addr  = paddr;
                    w_wdata = pwdata;
                    w_write = pwrite;
                    if (w_in_range) begin
                        w_next = ST_ISSUE;
                    end else begin
                        // ERR spends one silent cycle before responding so an
                        // error completes on the 2nd access cycle like a write.
                        w_next = ST_ERR;
                        w_cnt  = 4'd1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!psel) begin
                    w_next = ST_IDLE;
                end else if (!r_write) begin
                    w_next = ST_CAPTURE;
                end else if (WS != 4'd0) begin
                    w_next = ST_WAIT;
                    w_cnt  = WS;
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                if (!psel) begin
                    w_next = ST_IDLE;
                end else begin
                    w_prdata = mem_rd_data;
                    if (WS != 4'd0) begin
                        w_next = ST_WAIT;
                        w_cnt  = WS;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (!psel) begin
                    w_next = ST_IDLE;
                end else if (r_cnt <= 4'd1) begin
                    w_next = ST_DONE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                if (!psel || r_cnt == 4'd0) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign pready      = (r_state == ST_DONE) || (r_state == ST_ERR && r_cnt == 4'd0);
    assign pslverr     = (r_state == ST_ERR && r_cnt == 4'd0) ? RESP_SLVERR : RESP_OKAY;
    assign mem_ce      = (r_state == ST_ISSUE);
    assign mem_wren    = mem_ce && r_write;
    assign mem_rden    = mem_ce && !r_write;
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wdata;
    assign prdata      = r_prdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Directed bench for apb_mem_bridge: three instances (default, 2 wait states,
// 200-entry depth) each backed by a behavioural memory, with a scoreboard.
module tb_apb_mem_bridge;
    import apb_mem_defs::*;

    localparam int N = 3;

    logic       clk;
    logic       rst [N];
    logic       mem_init;
    logic       psel [N];
    logic       penable [N];
    logic       pwrite [N];
    logic [7:0] paddr [N];
    logic [7:0] pwdata [N];
    logic [7:0] prdata [N];
    logic       pready [N];
    logic       pslverr [N];
    logic       mem_ce [N];
    logic       mem_wren [N];
    logic       mem_rden [N];
    logic [7:0] mem_addr [N];
    logic [7:0] mem_wr_data [N];
    state_t     dbg_state [N];

    int n_total = 0;
    int n_bad   = 0;

    // {latency[7:0], pslverr, prdata[7:0]}
    logic [16:0] exp_q [$];

    logic [7:0] shadow [N][256];
    logic [7:0] model_prdata [N];
    int         ws [N];
    int         depth [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_inst
        logic [7:0] mem [256];
        logic [7:0] rd_q;
        int         ce_cnt = 0;
        int         both_cnt = 0;

        apb_mem_bridge #(
            .ADDR_W(8),
            .DATA_W(8),
            .MEM_DEPTH(g == 2 ? 200 : 256),
            .WAIT_STATES(g == 1 ? 2 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst[g]),
            .psel(psel[g]),
            .penable(penable[g]),
            .pwrite(pwrite[g]),
            .paddr(paddr[g]),
            .pwdata(pwdata[g]),
            .prdata(prdata[g]),
            .pready(pready[g]),
            .pslverr(pslverr[g]),
            .mem_ce(mem_ce[g]),
            .mem_wren(mem_wren[g]),
            .mem_rden(mem_rden[g]),
            .mem_addr(mem_addr[g]),
            .mem_wr_data(mem_wr_data[g]),
            .mem_rd_data(rd_q),
            .o_dbg_state(dbg_state[g])
        );

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
            end else if (mem_ce[g]) begin
                if (mem_rden[g]) rd_q <= mem[mem_addr[g]];
                else if (mem_wren[g]) mem[mem_addr[g]] <= mem_wr_data[g];
            end
        end

        always @(posedge clk) begin
            if (mem_ce[g]) ce_cnt <= ce_cnt + 1;
            if (mem_wren[g] && mem_rden[g]) both_cnt <= both_cnt + 1;
        end
    end

    function automatic logic [7:0] mem_peek(input int k, input logic [7:0] a);
        case (k)
            0:       mem_peek = g_inst[0].mem[a];
            1:       mem_peek = g_inst[1].mem[a];
            default: mem_peek = g_inst[2].mem[a];
        endcase
    endfunction

    function automatic int ce_peek(input int k);
        case (k)
            0:       ce_peek = g_inst[0].ce_cnt;
            1:       ce_peek = g_inst[1].ce_cnt;
            default: ce_peek = g_inst[2].ce_cnt;
        endcase
    endfunction

    function automatic int both_peek(input int k);
        case (k)
            0:       both_peek = g_inst[0].both_cnt;
            1:       both_peek = g_inst[1].both_cnt;
            default: both_peek = g_inst[2].both_cnt;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One APB transfer; expectations come from the shadow memory and the
    // latency rules, and leave the bus in the first IDLE cycle afterwards.
    task automatic apb_xfer(input int k, input logic wr, input logic [7:0] addr,
                            input logic [7:0] data);
        logic        err;
        logic [7:0]  exp_lat;
        logic [7:0]  exp_rd;
        logic [16:0] ent;
        int          lat;
        int          ce0;
        logic        seen;

        err = (int'(addr) >= depth[k]);
        if (err) exp_lat = 8'd2;
        else     exp_lat = 8'((wr ? 2 : 3) + ws[k]);
        if (!err && !wr) model_prdata[k] = shadow[k][addr];
        exp_rd = model_prdata[k];
        exp_q.push_back({exp_lat, err, exp_rd});
        if (!err && wr) shadow[k][addr] = data;

        ce0 = ce_peek(k);
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = addr;
        pwdata[k]  = data;
        step();
        penable[k] = 1'b1;
        seen = 1'b0;
        lat  = 1;
        while (!seen && lat <= 30) begin
            if (lat == 1 && !err) begin
                chk("issue_ce", 32'(mem_ce[k]), 32'd1);
                chk("issue_wren", 32'(mem_wren[k]), 32'(wr));
                chk("issue_rden", 32'(mem_rden[k]), 32'(!wr));
                chk("issue_addr", 32'(mem_addr[k]), 32'(addr));
                if (wr) chk("issue_wdata", 32'(mem_wr_data[k]), 32'(data));
            end
            if (pready[k]) begin
                seen = 1'b1;
                ent = exp_q.pop_front();
                chk("latency", 32'(lat), 32'(ent[16:9]));
                chk("pslverr", 32'(pslverr[k]), 32'(ent[8]));
                chk("prdata", 32'(prdata[k]), 32'(ent[7:0]));
            end else begin
                step();
                lat++;
            end
        end
        chk("pready_seen", 32'(seen), 32'd1);
        step();
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
        chk("strobe_count", 32'(ce_peek(k) - ce0), err ? 32'd0 : 32'd1);
    endtask

    initial begin
        int ce0;
        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            psel[k] = 1'b0;
            penable[k] = 1'b0;
            pwrite[k] = 1'b0;
            paddr[k] = 8'h00;
            pwdata[k] = 8'h00;
            model_prdata[k] = 8'h00;
            ws[k] = (k == 1) ? 2 : 0;
            depth[k] = (k == 2) ? 200 : 256;
            for (int i = 0; i < 256; i++) shadow[k][i] = 8'(i);
        end
        mem_init = 1'b1;
        idle(2);
        mem_init = 1'b0;
        for (int k = 0; k < N; k++) rst[k] = 1'b0;

        for (int k = 0; k < N; k++) begin
            chk("rst_pready", 32'(pready[k]), 32'd0);
            chk("rst_pslverr", 32'(pslverr[k]), 32'd0);
            chk("rst_prdata", 32'(prdata[k]), 32'd0);
            chk("rst_ce", 32'(mem_ce[k]), 32'd0);
            chk("rst_addr", 32'(mem_addr[k]), 32'd0);
            chk("rst_state", 32'(dbg_state[k]), 32'(ST_IDLE));
        end

        // Basic write, then read with idle hold of prdata
        apb_xfer(0, 1'b1, 8'h10, 8'hA5);
        chk("mem_after_write", 32'(mem_peek(0, 8'h10)), 32'hA5);
        idle(1);
        apb_xfer(0, 1'b0, 8'h3C, 8'h00);
        idle(3);
        chk("prdata_hold", 32'(prdata[0]), 32'h3C);

        // Back-to-back write then read, no idle gap
        apb_xfer(0, 1'b1, 8'h05, 8'h11);
        apb_xfer(0, 1'b0, 8'h05, 8'h00);
        chk("b2b_read", 32'(prdata[0]), 32'h11);

        // Reset during CAPTURE of a read
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h40;
        step();
        penable[0] = 1'b1;
        chk("rst_test_issue", 32'(dbg_state[0]), 32'(ST_ISSUE));
        step();
        chk("rst_test_capture", 32'(dbg_state[0]), 32'(ST_CAPTURE));
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        chk("midrst_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        chk("midrst_prdata", 32'(prdata[0]), 32'd0);
        chk("midrst_pready", 32'(pready[0]), 32'd0);
        chk("midrst_ce", 32'(mem_ce[0]), 32'd0);
        chk("midrst_addr", 32'(mem_addr[0]), 32'd0);
        chk("midrst_wdata", 32'(mem_wr_data[0]), 32'd0);
        model_prdata[0] = 8'h00;
        apb_xfer(0, 1'b0, 8'h10, 8'h00);

        // psel dropped during ISSUE: strobe completes, prdata untouched
        ce0 = ce_peek(0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 8'h22;
        step();
        psel[0] = 1'b0;
        step();
        chk("drop_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        chk("drop_strobes", 32'(ce_peek(0) - ce0), 32'd1);
        idle(1);
        chk("drop_prdata", 32'(prdata[0]), 32'(model_prdata[0]));

        // penable without a setup cycle is ignored
        ce0 = ce_peek(0);
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h30;
        step();
        chk("noset_state", 32'(dbg_state[0]), 32'(ST_IDLE));
        psel[0] = 1'b0; penable[0] = 1'b0;
        idle(1);
        chk("noset_strobes", 32'(ce_peek(0) - ce0), 32'd0);

        // Random traffic
        for (int i = 0; i < 8; i++) begin
            apb_xfer(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)));
            idle($urandom_range(0, 2));
        end

        // Two wait states
        apb_xfer(1, 1'b1, 8'h20, 8'h5A);
        apb_xfer(1, 1'b0, 8'h20, 8'h00);
        chk("ws_read", 32'(prdata[1]), 32'h5A);

        // Out-of-range write, then a boundary read
        apb_xfer(2, 1'b1, 8'hC8, 8'hFF);
        chk("err_mem_untouched", 32'(mem_peek(2, 8'hC8)), 32'hC8);
        apb_xfer(2, 1'b0, 8'hC7, 8'h00);
        chk("boundary_read", 32'(prdata[2]), 32'hC7);

        for (int k = 0; k < N; k++) chk("wren_rden_both", 32'(both_peek(k)), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
